// File: rtl/sram_queue_pkg.sv
// Shared defaults and width helpers for the SRAM-backed queue and its storage array.
package sram_queue_pkg;

    localparam int DEFAULT_WIDTH = 109;
    localparam int DEFAULT_DEPTH = 16;

    // Pointer width; kept at least 1 bit so a 2-entry array still gets a real address.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Count must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_queue_ram_1r1w.sv
// DEPTH x WIDTH storage with one write port and one registered read port; contents are never reset.
module ram_1r1w
    import sram_queue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = ptr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // rd_data holds its value between reads; the queue uses it as the head register.
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sram_queue.sv
// FIFO built on a 1R1W array whose registered read port doubles as the head register.
// Handshake: a transfer fires on a cycle where valid and ready are both high; io_enq_ready depends only on registered state.
module sram_queue
    import sram_queue_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    output logic             io_enq_ready,
    input  logic             io_enq_valid,
    input  logic [WIDTH-1:0] io_enq_bits,
    input  logic             io_deq_ready,
    output logic             io_deq_valid,
    output logic [WIDTH-1:0] io_deq_bits,
    input  logic             io_flush,
    output logic [CNT_W-1:0] io_count
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             head_valid;

    logic [CNT_W-1:0] array_occ;
    logic             enq_fire;
    logic             deq_fire;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign io_enq_ready = ~reset & (count < CNT_FULL);
    assign io_deq_valid = head_valid;
    assign io_count     = count;

    assign enq_fire  = io_enq_valid & io_enq_ready;
    assign deq_fire  = io_deq_valid & io_deq_ready;
    assign wr_en     = enq_fire & ~io_flush;
    // Entries still in the array, i.e. not yet loaded into the head register.
    assign array_occ = count - CNT_W'(head_valid);
    assign rd_en     = (array_occ != '0) & (~head_valid | deq_fire) & ~io_flush;

    ram_1r1w #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (io_enq_bits),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (io_deq_bits)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else if (io_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A completed read refills the head even when the old head leaves the same cycle.
            if (rd_en) begin
                head_valid <= 1'b1;
            end else if (deq_fire) begin
                head_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_queue.sv
// Directed and randomized bench for sram_queue against a queue-based reference model.
module tb_sram_queue;

    localparam int WIDTH = 109;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    logic             io_enq_ready;
    logic             io_enq_valid;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_deq_ready;
    logic             io_deq_valid;
    logic [WIDTH-1:0] io_deq_bits;
    logic             io_flush;
    logic [CNT_W-1:0] io_count;

    sram_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_ready (io_enq_ready),
        .io_enq_valid (io_enq_valid),
        .io_enq_bits  (io_enq_bits),
        .io_deq_ready (io_deq_ready),
        .io_deq_valid (io_deq_valid),
        .io_deq_bits  (io_deq_bits),
        .io_flush     (io_flush),
        .io_count     (io_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard: every entry held, oldest first, plus whether the head is visible
    logic [WIDTH-1:0] exp_q[$];
    bit               m_hv;
    int               n_checks;
    int               n_pass;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_model();
        check("count", WIDTH'(io_count), WIDTH'(exp_q.size()));
        check("deq_valid", WIDTH'(io_deq_valid), WIDTH'(m_hv));
        check("enq_ready", WIDTH'(io_enq_ready), WIDTH'(exp_q.size() < DEPTH));
        if (m_hv) check("deq_bits", io_deq_bits, exp_q[0]);
    endtask

    function automatic logic [WIDTH-1:0] rand_bits();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    // driver: apply inputs, advance one edge, update the model, check at the falling edge
    task automatic drive(input bit ev, input logic [WIDTH-1:0] eb, input bit dr, input bit fl);
        io_enq_valid = ev;
        io_enq_bits  = eb;
        io_deq_ready = dr;
        io_flush     = fl;
    endtask

    task automatic cycle();
        bit ef;
        bit df;
        bit rd;
        int occ;
        logic [WIDTH-1:0] eb;
        ef  = io_enq_valid && (exp_q.size() < DEPTH);
        df  = io_deq_ready && m_hv;
        occ = exp_q.size() - (m_hv ? 1 : 0);
        eb  = io_enq_bits;
        @(posedge clock);
        if (io_flush) begin
            exp_q.delete();
            m_hv = 1'b0;
        end else begin
            rd = (occ > 0) && (!m_hv || df);
            if (df) void'(exp_q.pop_front());
            if (ef) exp_q.push_back(eb);
            m_hv = rd ? 1'b1 : (df ? 1'b0 : m_hv);
        end
        @(negedge clock);
        check_model();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_hv     = 1'b0;
        reset    = 1'b1;
        drive(0, '0, 0, 0);

        // reset state
        repeat (2) @(negedge clock);
        check("rst_count", WIDTH'(io_count), '0);
        check("rst_deq_valid", WIDTH'(io_deq_valid), '0);
        check("rst_enq_ready", WIDTH'(io_enq_ready), '0);
        reset = 1'b0;
        #1;
        check("post_rst_enq_ready", WIDTH'(io_enq_ready), WIDTH'(1));

        // single entry latency
        drive(1, WIDTH'(1), 0, 0);
        cycle();
        check("single_count", WIDTH'(io_count), WIDTH'(1));
        check("single_valid_early", WIDTH'(io_deq_valid), '0);
        drive(0, '0, 0, 0);
        cycle();
        check("single_valid", WIDTH'(io_deq_valid), WIDTH'(1));
        check("single_bits", io_deq_bits, WIDTH'(1));
        drive(0, '0, 1, 0);
        cycle();

        // fill, then offer a fifth entry
        for (int i = 0; i < 4; i++) begin
            drive(1, WIDTH'(10 + i), 0, 0);
            cycle();
        end
        check("fill_count", WIDTH'(io_count), WIDTH'(4));
        check("fill_enq_ready", WIDTH'(io_enq_ready), '0);
        drive(1, WIDTH'(14), 0, 0);
        cycle();
        check("fifth_count", WIDTH'(io_count), WIDTH'(4));

        // drain on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", WIDTH'(io_deq_valid), WIDTH'(1));
            check("drain_bits", io_deq_bits, WIDTH'(10 + i));
            drive(0, '0, 1, 0);
            cycle();
            if (i == 0) check("drain_ready_back", WIDTH'(io_enq_ready), WIDTH'(1));
        end
        check("drained_valid", WIDTH'(io_deq_valid), '0);
        check("drained_count", WIDTH'(io_count), '0);

        // streaming: one in and one out every cycle once primed
        for (int i = 0; i < 22; i++) begin
            drive(1, WIDTH'(100 + i), 1, 0);
            cycle();
            if (i >= 2) check("stream_count", WIDTH'(io_count), WIDTH'(2));
            if (i >= 2) check("stream_bits", io_deq_bits, WIDTH'(100 + i - 1));
        end
        drive(0, '0, 1, 0);
        repeat (3) cycle();

        // flush with three held and an enqueue offered
        for (int i = 0; i < 3; i++) begin
            drive(1, WIDTH'(40 + i), 0, 0);
            cycle();
        end
        drive(1, WIDTH'(99), 1, 1);
        cycle();
        check("flush_count", WIDTH'(io_count), '0);
        check("flush_valid", WIDTH'(io_deq_valid), '0);
        drive(1, WIDTH'(5), 0, 0);
        cycle();
        drive(0, '0, 0, 0);
        cycle();
        check("post_flush_bits", io_deq_bits, WIDTH'(5));
        check("post_flush_count", WIDTH'(io_count), WIDTH'(1));

        // randomized traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_bits(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0));
            cycle();
        end

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1, rand_bits(), 0, 0);
            cycle();
        end
        drive(0, '0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_count", WIDTH'(io_count), '0);
        check("async_deq_valid", WIDTH'(io_deq_valid), '0);
        check("async_enq_ready", WIDTH'(io_enq_ready), '0);
        exp_q.delete();
        m_hv = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), rand_bits(), 1'($urandom_range(0, 3) != 0), 1'b0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_queue.md
SRAM_QUEUE -- requirements
Module: sram_queue

Interface
REQ-001 Parameter WIDTH, default 109, payload width in bits; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 16, total entry capacity; SHALL be at least 2; a power of two is not required.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 io_enq_ready  out  1  the queue accepts io_enq_bits this cycle.
REQ-006 io_enq_valid  in  1  the producer offers io_enq_bits.
REQ-007 io_enq_bits  in  WIDTH  enqueue payload.
REQ-008 io_deq_ready  in  1  the consumer takes the head entry.
REQ-009 io_deq_valid  out  1  the head entry is present on io_deq_bits.
REQ-010 io_deq_bits  out  WIDTH  head payload, driven from a register.
REQ-011 io_flush  in  1  synchronous discard of all contents.
REQ-012 io_count  out  clog2(DEPTH+1)  entries held, including the head register.

Function
REQ-013 Enqueue fire = io_enq_valid & io_enq_ready; dequeue fire = io_deq_valid & io_deq_ready.
REQ-014 io_enq_ready SHALL equal (io_count < DEPTH) and SHALL depend only on registered state, with no path from io_deq_ready.
REQ-015 Storage SHALL be a DEPTH-entry 1R1W array with a registered read; the read register is the head register driving io_deq_bits.
REQ-016 Write pointer and read pointer SHALL each advance by 1 on their operation and wrap from DEPTH-1 to 0.
REQ-017 Array occupancy is io_count minus io_deq_valid.
REQ-018 A read SHALL be issued when array occupancy is greater than 0 and either io_deq_valid=0 or a dequeue fires this cycle.
REQ-019 On the edge that completes a read, the head register SHALL load the data and io_deq_valid SHALL be 1.
REQ-020 Latency: an enqueue at edge N into an empty queue SHALL give io_deq_valid=1 after edge N+1.
REQ-021 Throughput: sustained enqueue and dequeue SHALL reach 1 entry per cycle.
REQ-022 A write and a read of the same array entry in the same cycle is impossible by construction, because a read needs occupancy greater than 0 before the write lands.
REQ-023 io_count update: +1 on enqueue fire only, -1 on dequeue fire only, unchanged on both or neither.
REQ-024 Full (io_count=DEPTH): io_enq_ready=0; a dequeue fire SHALL raise io_enq_ready on the following cycle.
REQ-025 Empty: io_deq_valid=0 and io_deq_bits holds its last value; io_deq_bits is don't-care whenever io_deq_valid=0.
REQ-026 Entries SHALL leave the queue in strict FIFO order.
REQ-027 io_flush=1 SHALL take priority over any enqueue or dequeue that cycle.
REQ-028 After a flush edge: both pointers=0, io_count=0, io_deq_valid=0, and any read in flight is discarded.
REQ-029 When io_flush=1, io_enq_ready SHALL still reflect pre-flush state, but no write SHALL occur.

Reset
REQ-030 While reset=1: pointers=0, io_count=0, io_deq_valid=0, io_enq_ready=0.
REQ-031 io_enq_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Array contents and io_deq_bits SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries, including any read in flight.

Structure
REQ-034 Shared package sram_queue_pkg SHALL hold the default WIDTH and DEPTH and a function computing pointer and count widths.
REQ-035 The storage SHALL be one sub-module, ram_1r1w, parametrised by WIDTH and DEPTH.
REQ-036 ram_1r1w SHALL have one write port and one registered-read port, with no reset on the array.
REQ-037 Pointers, count and head-valid logic SHALL live in sram_queue.

Verification (WIDTH=109, DEPTH=4)
REQ-038 Single entry: enqueue 0x1 into an empty queue at edge 0 -> io_deq_valid=1 with io_deq_bits=0x1 after edge 1; io_count=1.
REQ-039 Fill: enqueue 0xA,0xB,0xC,0xD with io_deq_ready=0 -> io_count=4, io_enq_ready=0; a fifth offer is not accepted.
REQ-040 Drain: drain the full queue with io_deq_ready=1 -> outputs 0xA,0xB,0xC,0xD on consecutive cycles, then io_deq_valid=0 and io_count=0.
REQ-041 Streaming: enqueue and dequeue every cycle for 20 cycles -> 1 entry per cycle; io_count stays constant once primed; pointers wrap correctly.
REQ-042 Flush: flush with 3 entries held and an enqueue offered the same cycle -> io_count=0 and io_deq_valid=0 next cycle; the next enqueued value 0x5 is the first value out.
REQ-043 Reset: assert reset asynchronously mid-stream -> outputs reach their reset values immediately without a clock edge; no stale entry appears after release.
